// File: rtl/core_pipe_pkg.sv
// Shared pipeline payload widths, id_ex field offsets and occupancy codes.
// Imported by every stage register and its helpers.
package core_pipe_pkg;

  // id_ex payload: op, fn, rs1, rs2, rd, we, mem, br, imm, tag
  localparam int ID_EX_W  = 220;
  localparam int EX_MEM_W = 64 + 64 + 5 + 1 + 1 + 8;
  localparam int MEM_WB_W = 64 + 5 + 1 + 8;

  localparam int OFF_OP  = 0;
  localparam int OFF_FN  = OFF_OP  + 8;
  localparam int OFF_RS1 = OFF_FN  + 4;
  localparam int OFF_RS2 = OFF_RS1 + 64;
  localparam int OFF_RD  = OFF_RS2 + 64;
  localparam int OFF_WE  = OFF_RD  + 5;
  localparam int OFF_MEM = OFF_WE  + 1;
  localparam int OFF_BR  = OFF_MEM + 1;
  localparam int OFF_IMM = OFF_BR  + 1;
  localparam int OFF_TAG = OFF_IMM + 64;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  function automatic logic [1:0] occ_of(
    input logic i_main_v,
    input logic i_skid_v
  );
    return {1'b0, i_main_v} + {1'b0, i_skid_v};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, i_clr (sync clear), i_inc (count enable), o_cnt (value).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with 2-entry skid, flush, stall, blocked-cycle count.
// Ports: in_* upstream handshake, out_* downstream, stall_i, flush_i, count_o, stall_cnt_o.
module pipe_skid_stage
  import core_pipe_pkg::*;
#(
  parameter int DATA_W = ID_EX_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic [1:0]        count_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic              r_main_v;
  logic              r_skid_v;
  logic [DATA_W-1:0] r_main_d;
  logic [DATA_W-1:0] r_skid_d;

  logic       w_in_ready;
  logic       w_out_valid;
  logic       w_in_fire;
  logic       w_out_fire;
  logic       w_cnt_inc;
  logic [1:0] w_occ;

  // ready looks only at registered state, never at out_ready_i
  assign w_in_ready  = !r_skid_v && !stall_i && !flush_i;
  assign w_out_valid = r_main_v && !stall_i && !flush_i;
  assign w_in_fire   = in_valid_i && w_in_ready;
  assign w_out_fire  = w_out_valid && out_ready_i;
  assign w_occ       = occ_of(r_main_v, r_skid_v);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
      r_main_d <= '0;
      r_skid_d <= '0;
    end else if (flush_i) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (!stall_i) begin
      case (w_occ)
        OCC_EMPTY: begin
          if (w_in_fire) begin
            r_main_v <= 1'b1;
            r_main_d <= in_data_i;
          end
        end
        OCC_ONE: begin
          if (w_in_fire && w_out_fire) begin
            r_main_d <= in_data_i;
          end else if (w_in_fire) begin
            r_skid_v <= 1'b1;
            r_skid_d <= in_data_i;
          end else if (w_out_fire) begin
            r_main_v <= 1'b0;
          end
        end
        OCC_TWO: begin
          // skid holds the younger payload; it moves up
          if (w_out_fire) begin
            r_main_d <= r_skid_d;
            r_skid_v <= 1'b0;
          end
        end
        default: begin
          r_main_v <= 1'b0;
          r_skid_v <= 1'b0;
        end
      endcase
    end
  end

  assign w_cnt_inc = (stall_i && !flush_i) ||
                     (r_main_v && !out_ready_i && !stall_i && !flush_i);

  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .i_clr(rst),
    .i_inc(w_cnt_inc),
    .o_cnt(stall_cnt_o)
  );

  assign in_ready_o  = w_in_ready;
  assign out_valid_o = w_out_valid;
  assign out_data_o  = r_main_d;
  assign count_o     = w_occ;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage with a payload scoreboard.
// A second instance with a 4-bit counter covers saturation.
module tb_pipe_skid_stage;

  localparam int DW = 220;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic          stall, flush;
  logic [DW-1:0] in_data, out_data;
  logic [1:0]    count;
  logic [15:0]   scnt;

  logic          s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [SW-1:0] s_in_data, s_out_data;
  logic [1:0]    s_count;
  logic [3:0]    s_scnt;

  int n_chk  = 0;
  int n_pass = 0;
  bit mon_en = 1'b0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  pipe_skid_stage #(.DATA_W(DW), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .stall_i(stall), .flush_i(flush),
    .count_o(count), .stall_cnt_o(scnt)
  );

  pipe_skid_stage #(.DATA_W(SW), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst),
    .in_valid_i(s_in_valid), .in_ready_o(s_in_ready), .in_data_i(s_in_data),
    .out_valid_o(s_out_valid), .out_ready_i(s_out_ready), .out_data_o(s_out_data),
    .stall_i(1'b0), .flush_i(1'b0),
    .count_o(s_count), .stall_cnt_o(s_scnt)
  );

  function automatic logic [DW-1:0] mk(input logic [31:0] v);
    return DW'({7{v}});
  endfunction

  task automatic chk(input string nm, input logic [255:0] got,
                     input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, got, exp);
  endtask

  task automatic nx();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // scoreboard monitor: every downstream transfer pops one expectation
  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 256'(out_data), 256'(0));
        if (out_data == '0) begin
          n_pass--;
          $display("FAIL unexpected_out: got transfer want none");
        end
      end else begin
        chk("out_data", 256'(out_data), 256'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_data = mk(32'hAB);
    out_ready = 1'b1; stall = 1'b0; flush = 1'b0;
    s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b1;

    // reset
    @(posedge clk); @(posedge clk);
    smp();
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_out_data", 256'(out_data), 256'(0));
    chk("rst_count", 256'(count), 256'(0));
    chk("rst_stall_cnt", 256'(scnt), 256'(0));
    nx(); rst = 1'b0; in_valid = 1'b0;
    smp();
    chk("rst_in_ready", 256'(in_ready), 256'(1));
    mon_en = 1'b1;

    // streaming
    nx(); in_valid = 1'b1; in_data = mk(32'h1); exp_q.push_back(mk(32'h1));
    smp(); chk("str_count0", 256'(count), 256'(0));
    chk("str_in_ready", 256'(in_ready), 256'(1));
    nx(); in_data = mk(32'h2); exp_q.push_back(mk(32'h2));
    smp(); chk("str_count1", 256'(count), 256'(1));
    nx(); in_data = mk(32'h3); exp_q.push_back(mk(32'h3));
    smp(); chk("str_count2", 256'(count), 256'(1));
    nx(); in_valid = 1'b0;
    smp(); chk("str_count3", 256'(count), 256'(1));
    nx();
    smp(); chk("str_count4", 256'(count), 256'(0));
    chk("str_scnt", 256'(scnt), 256'(0));

    // backpressure into skid
    nx(); out_ready = 1'b0; in_valid = 1'b1; in_data = mk(32'h10);
    exp_q.push_back(mk(32'h10));
    smp(); chk("bp_rdy0", 256'(in_ready), 256'(1));
    nx(); in_data = mk(32'h11); exp_q.push_back(mk(32'h11));
    smp(); chk("bp_count1", 256'(count), 256'(1));
    nx(); in_data = mk(32'h12);
    smp(); chk("bp_count2", 256'(count), 256'(2));
    chk("bp_rdy2", 256'(in_ready), 256'(0));
    nx(); out_ready = 1'b1;
    smp(); chk("bp_rdy3", 256'(in_ready), 256'(0));
    chk("bp_count3", 256'(count), 256'(2));
    nx(); exp_q.push_back(mk(32'h12));
    smp(); chk("bp_rdy4", 256'(in_ready), 256'(1));
    chk("bp_count4", 256'(count), 256'(1));
    nx(); in_valid = 1'b0;
    smp(); chk("bp_count5", 256'(count), 256'(1));
    nx();
    smp(); chk("bp_count6", 256'(count), 256'(0));
    chk("bp_scnt", 256'(scnt), 256'(2));

    // stall while holding one payload
    nx(); out_ready = 1'b0; in_valid = 1'b1; in_data = mk(32'h20);
    exp_q.push_back(mk(32'h20));
    smp();
    nx(); stall = 1'b1; out_ready = 1'b1; in_data = mk(32'h21);
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("st_in_ready", 256'(in_ready), 256'(0));
      chk("st_out_valid", 256'(out_valid), 256'(0));
      chk("st_count", 256'(count), 256'(1));
      chk("st_scnt", 256'(scnt), 256'(2 + i));
      if (i < 2) nx();
    end
    nx(); stall = 1'b0; in_valid = 1'b0;
    smp(); chk("st_out_valid_after", 256'(out_valid), 256'(1));
    chk("st_scnt_total", 256'(scnt), 256'(5));
    nx();
    smp(); chk("st_count_end", 256'(count), 256'(0));

    // flush from full, with stall and a new offer
    nx(); out_ready = 1'b0; in_valid = 1'b1; in_data = mk(32'h30);
    smp();
    nx(); in_data = mk(32'h31);
    smp();
    nx(); flush = 1'b1; stall = 1'b1; in_data = mk(32'h32);
    smp(); chk("fl_count_pre", 256'(count), 256'(2));
    chk("fl_in_ready", 256'(in_ready), 256'(0));
    chk("fl_out_valid", 256'(out_valid), 256'(0));
    chk("fl_scnt_pre", 256'(scnt), 256'(6));
    nx(); flush = 1'b0; stall = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    smp(); chk("fl_count", 256'(count), 256'(0));
    chk("fl_out_valid_post", 256'(out_valid), 256'(0));
    chk("fl_scnt_post", 256'(scnt), 256'(6));
    nx(); in_valid = 1'b1; in_data = mk(32'h33); exp_q.push_back(mk(32'h33));
    smp();
    nx(); in_valid = 1'b0;
    smp();
    nx();
    smp(); chk("fl_count_end", 256'(count), 256'(0));

    // saturation on the 4-bit counter instance
    nx(); s_out_ready = 1'b0; s_in_valid = 1'b1; s_in_data = 8'h5A;
    smp(); chk("sat_cnt0", 256'(s_scnt), 256'(0));
    nx(); s_in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      smp();
      chk("sat_cnt", 256'(s_scnt), 256'((i < 15) ? i : 15));
      nx();
    end
    smp(); chk("sat_cnt_final", 256'(s_scnt), 256'(15));
    chk("sat_data", 256'(s_out_data), 256'(8'h5A));
    chk("sat_count", 256'(s_count), 256'(1));

    chk("queue_empty", 256'(exp_q.size()), 256'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
